bkq_enq_arbiter: RTL and testbench
==================================

BKQ_ENQ_ARBITER -- requirements
Module: bkq_enq_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 64, flattened payload width.
REQ-003 SHALL have parameter MAXBR, default 8, branch-mask width.
REQ-004 SHALL have port clock  in  1  clock, rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester request valid.
REQ-007 SHALL have port req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-008 SHALL have port req_data  in  NREQ*DATA_W  payloads; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_br_mask  in  NREQ*MAXBR  branch masks; requester i at bits [i*MAXBR +: MAXBR].
REQ-010 SHALL have port req_uses_ldq  in  NREQ  per-requester flush-sensitive flag.
REQ-011 SHALL have port br_resolve_mask  in  MAXBR  branches resolved this cycle.
REQ-012 SHALL have port br_mispredict_mask  in  MAXBR  branches mispredicted this cycle.
REQ-013 SHALL have port flush  in  1  pipeline flush; kills uses_ldq entries.
REQ-014 SHALL have port enq_valid  out  1  valid toward the branch-killable queue enqueue port.
REQ-015 SHALL have port enq_ready  in  1  queue enqueue ready.
REQ-016 SHALL have ports enq_data (DATA_W), enq_br_mask (MAXBR), enq_uses_ldq (1) and enq_src ($clog2(NREQ)), all outputs: held payload, updated mask, flag, winning requester index.

Function
REQ-017 SHALL hold one output entry (hold_valid, data, br_mask, uses_ldq, src) plus a round-robin pointer rr_ptr.
REQ-018 SHALL define kill(m,u) = ((m & br_mask_mispredict) != 0) || (flush && u); upd(m) = m & ~br_resolve_mask.
REQ-019 SHALL treat requester i as eligible when req_valid[i] && !kill(its mask, its uses_ldq).
REQ-020 SHALL pick the winner as the first eligible index found searching from rr_ptr upward, wrapping NREQ-1 to 0.
REQ-021 SHALL define load_en = !hold_valid || (enq_valid && enq_ready) || kill(held mask, held uses_ldq).
REQ-022 SHALL assert req_ready only for the winner, and only when load_en; zero otherwise.
REQ-023 SHALL, on accept, capture payload, upd(mask), uses_ldq and index into the hold register next edge, and set rr_ptr to winner+1 mod NREQ.
REQ-024 SHALL leave rr_ptr unchanged on cycles with no accept.
REQ-025 SHALL drive enq_valid = hold_valid && !kill(held mask, held uses_ldq); enq_br_mask = upd(held mask).
REQ-026 SHALL, each cycle the held entry is retained, update its mask to upd(mask); a killed held entry SHALL be cleared unless replaced.
REQ-027 SHALL support drain and load in the same cycle: latency accept-to-enq_valid is 1 cycle; throughput 1 per cycle with enq_ready high.
REQ-028 SHALL hold data and enq_src stable while enq_valid && !enq_ready, except for mask updates.
REQ-029 SHALL never grant an ineligible requester; dropping killed requests is the requester's responsibility.

Reset
REQ-030 SHALL, on reset, clear hold_valid and rr_ptr to 0; enq_valid and req_ready are 0 during reset, and a held entry is discarded when reset asserts mid-operation.
REQ-031 SHALL make outputs enq_data, enq_br_mask, enq_uses_ldq and enq_src don't-care while enq_valid is 0.

Configuration
REQ-032 SHALL, with BKQ_ARB_KILL_CNT_EN defined, add output kill_count (16 bits, reset 0). It increments once per held entry dropped by kill, including an entry killed in the same cycle it is replaced, and saturates at 0xFFFF.
REQ-033 SHALL, without BKQ_ARB_KILL_CNT_EN, omit the kill_count port and counter entirely; all other behaviour is identical.

Verification
REQ-034 SHALL cover: req_valid=4'b1111, enq_ready=1 continuously, rr_ptr=0 -> accepts in order 0,1,2,3,0; enq_src follows one cycle later.
REQ-035 SHALL cover: held mask 8'h04, enq_ready=0, br_mispredict_mask=8'h04 -> enq_valid=0 that cycle; a pending req_valid[2] is accepted the same cycle; with the macro on, kill_count=1.
REQ-036 SHALL cover: held mask 8'h06, br_resolve_mask=8'h02 -> enq_br_mask=8'h04 that cycle; held mask reads 8'h04 next cycle.
REQ-037 SHALL cover: flush=1, req_valid=4'b0011, req_uses_ldq=4'b0001, rr_ptr=0 -> req_ready=4'b0010; a held uses_ldq entry is dropped.
REQ-038 SHALL cover: reset asserted while hold_valid=1, enq_ready=0 -> enq_valid=0 immediately; after release, the first accepted requester is the lowest eligible index.
REQ-039 SHALL cover: enq_ready toggling 1,0,1 with req_valid[1] held high -> no payload lost or duplicated; rr_ptr=2 after the first accept.

Source files
------------

// File: rtl/bkq_enq_arbiter.sv
// Round-robin arbiter feeding a single held entry toward a branch-killable queue enqueue port.
// Define BKQ_ARB_KILL_CNT_EN to add a saturating kill_count output.
module bkq_enq_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 64,
  parameter int MAXBR  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  input  logic [NREQ*MAXBR-1:0]     req_br_mask,
  input  logic [NREQ-1:0]           req_uses_ldq,
  input  logic [MAXBR-1:0]          br_resolve_mask,
  input  logic [MAXBR-1:0]          br_mispredict_mask,
  input  logic                      flush,
  output logic                      enq_valid,
  input  logic                      enq_ready,
  output logic [DATA_W-1:0]         enq_data,
  output logic [MAXBR-1:0]          enq_br_mask,
  output logic                      enq_uses_ldq,
  output logic [$clog2(NREQ)-1:0]   enq_src
`ifdef BKQ_ARB_KILL_CNT_EN
  ,
  output logic [15:0]               kill_count
`endif
);

  localparam int SRC_W = $clog2(NREQ);
  localparam logic [SRC_W:0] NREQ_W = (SRC_W+1)'(NREQ);

  function automatic logic kill_fn(input logic [MAXBR-1:0] m, input logic u,
                                   input logic [MAXBR-1:0] mp, input logic fl);
    kill_fn = ((m & mp) != {MAXBR{1'b0}}) || (fl && u);
  endfunction

  function automatic logic [MAXBR-1:0] upd_fn(input logic [MAXBR-1:0] m,
                                              input logic [MAXBR-1:0] res);
    upd_fn = m & ~res;
  endfunction

  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MAXBR-1:0]    mask_q, mask_d;
  logic                uses_q, uses_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0]     eligible;
  logic                found;
  logic [SRC_W-1:0]    winner;
  logic [DATA_W-1:0]   sel_data;
  logic [MAXBR-1:0]    sel_mask;
  logic                sel_uses;
  logic                held_kill;
  logic                drain;
  logic                load_en;
  logic                accept;
  logic [SRC_W:0]      next_ptr;

  // Requesters whose own entry is not being killed this cycle may compete.
  always_comb begin
    eligible = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] &&
                    !kill_fn(req_br_mask[i*MAXBR +: MAXBR], req_uses_ldq[i],
                             br_mispredict_mask, flush);
    end
  end

  // First eligible index at or above rr_ptr, wrapping at NREQ.
  always_comb begin
    logic [SRC_W:0] sum;
    found  = 1'b0;
    winner = {SRC_W{1'b0}};
    sum    = {(SRC_W+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end else begin
        sum = sum;
      end
      if (!found && eligible[sum[SRC_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[SRC_W-1:0];
      end else begin
        found  = found;
      end
    end
  end

  // Mux the winning requester's payload, mask and flag.
  always_comb begin
    sel_data = {DATA_W{1'b0}};
    sel_mask = {MAXBR{1'b0}};
    sel_uses = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (SRC_W'(i) == winner) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_mask = req_br_mask[i*MAXBR +: MAXBR];
        sel_uses = req_uses_ldq[i];
      end else begin
        sel_data = sel_data;
      end
    end
  end

  // Hold-register control: drain, kill and load may all happen in one cycle.
  always_comb begin
    held_kill = hold_valid_q && kill_fn(mask_q, uses_q, br_mispredict_mask, flush);
    enq_valid = hold_valid_q && !held_kill && !reset;
    drain     = enq_valid && enq_ready;
    load_en   = !hold_valid_q || drain || held_kill;
    accept    = load_en && found && !reset;

    hold_valid_d = hold_valid_q;
    data_d       = data_q;
    mask_d       = upd_fn(mask_q, br_resolve_mask);
    uses_d       = uses_q;
    src_d        = src_q;
    rr_ptr_d     = rr_ptr_q;
    next_ptr     = {1'b0, winner} + (SRC_W+1)'(1);

    if (accept) begin
      hold_valid_d = 1'b1;
      data_d       = sel_data;
      mask_d       = upd_fn(sel_mask, br_resolve_mask);
      uses_d       = sel_uses;
      src_d        = winner;
      if (next_ptr >= NREQ_W) begin
        rr_ptr_d = {SRC_W{1'b0}};
      end else begin
        rr_ptr_d = next_ptr[SRC_W-1:0];
      end
    end else if (drain || held_kill) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // One-hot grant to the winner only when the hold register can take it.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (SRC_W'(i) == winner);
    end
  end

  // Held entry is presented with this cycle's resolutions already applied.
  always_comb begin
    enq_data     = data_q;
    enq_br_mask  = upd_fn(mask_q, br_resolve_mask);
    enq_uses_ldq = uses_q;
    enq_src      = src_q;
  end

  // Hold register and round-robin pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      data_q       <= {DATA_W{1'b0}};
      mask_q       <= {MAXBR{1'b0}};
      uses_q       <= 1'b0;
      src_q        <= {SRC_W{1'b0}};
      rr_ptr_q     <= {SRC_W{1'b0}};
    end else begin
      hold_valid_q <= hold_valid_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      uses_q       <= uses_d;
      src_q        <= src_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

`ifdef BKQ_ARB_KILL_CNT_EN
  logic [15:0] kill_cnt_q, kill_cnt_d;

  // Count held entries lost to a kill, even when a new entry replaces them.
  always_comb begin
    if (held_kill && (kill_cnt_q != 16'hFFFF)) begin
      kill_cnt_d = kill_cnt_q + 16'd1;
    end else begin
      kill_cnt_d = kill_cnt_q;
    end
    kill_count = kill_cnt_q;
  end

  // Saturating kill counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kill_cnt_q <= 16'h0000;
    end else begin
      kill_cnt_q <= kill_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bkq_enq_arbiter.sv
// Directed self-checking bench for bkq_enq_arbiter (NREQ=4, DATA_W=64, MAXBR=8).
module tb_bkq_enq_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 64;
  localparam int MAXBR  = 8;

  logic                   clock;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*MAXBR-1:0]  req_br_mask;
  logic [NREQ-1:0]        req_uses_ldq;
  logic [MAXBR-1:0]       br_resolve_mask;
  logic [MAXBR-1:0]       br_mispredict_mask;
  logic                   flush;
  logic                   enq_valid;
  logic                   enq_ready;
  logic [DATA_W-1:0]      enq_data;
  logic [MAXBR-1:0]       enq_br_mask;
  logic                   enq_uses_ldq;
  logic [1:0]             enq_src;
`ifdef BKQ_ARB_KILL_CNT_EN
  logic [15:0]            kill_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  bkq_enq_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .MAXBR(MAXBR)) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_data           (req_data),
    .req_br_mask        (req_br_mask),
    .req_uses_ldq       (req_uses_ldq),
    .br_resolve_mask    (br_resolve_mask),
    .br_mispredict_mask (br_mispredict_mask),
    .flush              (flush),
    .enq_valid          (enq_valid),
    .enq_ready          (enq_ready),
    .enq_data           (enq_data),
    .enq_br_mask        (enq_br_mask),
    .enq_uses_ldq       (enq_uses_ldq),
    .enq_src            (enq_src)
`ifdef BKQ_ARB_KILL_CNT_EN
    ,
    .kill_count         (kill_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    req_valid          = 4'b1111;
    req_uses_ldq       = 4'b0000;
    req_br_mask        = '0;
    br_resolve_mask    = 8'h00;
    br_mispredict_mask = 8'h00;
    flush              = 1'b0;
    enq_ready          = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = 64'hDD00 + 64'(i);

    tick();
    tick();
    #1;
    check_eq("rst_enq_valid", 64'(enq_valid), 64'h0);
    check_eq("rst_req_ready", 64'(req_ready), 64'h0);
    reset = 1'b0;
    #1;

    // Round-robin order 0,1,2,3,0 with enq_src one cycle behind
    for (int k = 0; k < 5; k++) begin
      check_eq("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        check_eq("rr_enq_valid", 64'(enq_valid), 64'h1);
        check_eq("rr_enq_src", 64'(enq_src), 64'((k - 1) % 4));
        check_eq("rr_enq_data", enq_data, 64'hDD00 + 64'((k - 1) % 4));
      end
      tick();
      #1;
    end
    req_valid = 4'b0000;
    #1;
    check_eq("drain_valid", 64'(enq_valid), 64'h1);
    check_eq("drain_src", 64'(enq_src), 64'h0);
    check_eq("drain_ready", 64'(req_ready), 64'h0);
    tick();

    // Mask resolution on a retained entry (rr_ptr=1)
    req_br_mask[2*MAXBR +: MAXBR] = 8'h06;
    req_valid = 4'b0100;
    enq_ready = 1'b0;
    #1;
    check_eq("res_load_ready", 64'(req_ready), 64'b0100);
    check_eq("res_empty_valid", 64'(enq_valid), 64'h0);
    tick();
    req_valid       = 4'b0000;
    br_resolve_mask = 8'h02;
    #1;
    check_eq("res_valid", 64'(enq_valid), 64'h1);
    check_eq("res_mask_now", 64'(enq_br_mask), 64'h04);
    tick();
    br_resolve_mask = 8'h00;
    #1;
    check_eq("res_mask_next", 64'(enq_br_mask), 64'h04);

    // Mispredict kills held mask 04 while requester 2 replaces it
    req_data[2*DATA_W +: DATA_W]  = 64'hDD22;
    req_br_mask[2*MAXBR +: MAXBR] = 8'h01;
    req_valid          = 4'b0100;
    br_mispredict_mask = 8'h04;
    #1;
    check_eq("kill_enq_valid", 64'(enq_valid), 64'h0);
    check_eq("kill_replace_ready", 64'(req_ready), 64'b0100);
    tick();
    br_mispredict_mask = 8'h00;
    req_valid          = 4'b0000;
    #1;
    check_eq("repl_valid", 64'(enq_valid), 64'h1);
    check_eq("repl_src", 64'(enq_src), 64'h2);
    check_eq("repl_data", enq_data, 64'hDD22);
    check_eq("repl_mask", 64'(enq_br_mask), 64'h01);
`ifdef BKQ_ARB_KILL_CNT_EN
    check_eq("kill_count_1", 64'(kill_count), 64'h1);
`endif
    enq_ready = 1'b1;
    tick();

    // Flush: load uses_ldq entry from requester 3 (rr_ptr=3 -> 0), then flush it
    req_br_mask[2*MAXBR +: MAXBR] = 8'h00;
    req_valid    = 4'b1000;
    req_uses_ldq = 4'b1000;
    enq_ready    = 1'b0;
    #1;
    check_eq("ldq_load_ready", 64'(req_ready), 64'b1000);
    tick();
    flush        = 1'b1;
    req_valid    = 4'b0011;
    req_uses_ldq = 4'b0001;
    #1;
    check_eq("flush_ready", 64'(req_ready), 64'b0010);
    check_eq("flush_enq_valid", 64'(enq_valid), 64'h0);
    tick();
    flush        = 1'b0;
    req_valid    = 4'b0000;
    req_uses_ldq = 4'b0000;
    enq_ready    = 1'b1;
    #1;
    check_eq("flush_after_valid", 64'(enq_valid), 64'h1);
    check_eq("flush_after_src", 64'(enq_src), 64'h1);
    check_eq("flush_after_data", enq_data, 64'hDD01);
    check_eq("flush_after_ldq", 64'(enq_uses_ldq), 64'h0);
`ifdef BKQ_ARB_KILL_CNT_EN
    check_eq("kill_count_2", 64'(kill_count), 64'h2);
`endif
    tick();

    // enq_ready 1,0,1 with requester 1 streaming payloads A1 then A2 (rr_ptr=2)
    req_data[1*DATA_W +: DATA_W] = 64'hA1;
    req_valid = 4'b0010;
    enq_ready = 1'b1;
    #1;
    check_eq("tog_ready_0", 64'(req_ready), 64'b0010);
    tick();
    check_eq("tog_rr_ptr", 64'(dut.rr_ptr_q), 64'h2);
    req_data[1*DATA_W +: DATA_W] = 64'hA2;
    enq_ready = 1'b0;
    #1;
    check_eq("tog_stall_ready", 64'(req_ready), 64'h0);
    check_eq("tog_stall_valid", 64'(enq_valid), 64'h1);
    check_eq("tog_stall_data", enq_data, 64'hA1);
    tick();
    enq_ready = 1'b1;
    #1;
    check_eq("tog_go_valid", 64'(enq_valid), 64'h1);
    check_eq("tog_go_data", enq_data, 64'hA1);
    check_eq("tog_go_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    check_eq("tog_next_valid", 64'(enq_valid), 64'h1);
    check_eq("tog_next_data", enq_data, 64'hA2);
    tick();

    // Reset with a held entry and enq_ready low
    req_valid = 4'b0100;
    enq_ready = 1'b0;
    #1;
    check_eq("pre_rst_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b0110;
    reset     = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(enq_valid), 64'h0);
    check_eq("mid_rst_ready", 64'(req_ready), 64'h0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_valid", 64'(enq_valid), 64'h0);
    check_eq("post_rst_ready", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    check_eq("post_rst_src", 64'(enq_src), 64'h1);
    check_eq("post_rst_enq", 64'(enq_valid), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
